// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch stage.
// FSM state encoding, NOP word, PC step and reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DROP
    } fetch_state_e;

    localparam logic [31:0] INST_NOP     = 32'h0000_0000;
    localparam int unsigned PC_STEP      = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction memory req/ready handshake bundle.
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if #(
    parameter int S = 32
);

    logic         imem_req;
    logic [S-1:0] imem_addr;
    logic         imem_ready;
    logic [S-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_pc_reg.sv
// Program counter register.
// Redirect (word aligned) beats increment beats hold.
module if_pc_reg
    import mips_pkg::*;
#(
    parameter int           S        = 32,
    parameter logic [S-1:0] RESET_PC = S'(DEF_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect,
    input  logic [S-1:0] redirect_pc,
    input  logic         inc,
    input  logic [S-1:0] base,
    output logic [S-1:0] pc,
    output logic [S-1:0] pc_nxt
);

    localparam logic [S-1:0] ALIGN = ~S'(3);

    // select next pc: aligned redirect target, base+4, or hold
    always_comb begin
        pc_nxt = pc;
        if (redirect) begin
            pc_nxt = redirect_pc & ALIGN;
        end else if (inc) begin
            pc_nxt = base + S'(PC_STEP);
        end
    end

    // pc state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC and feeds IF/ID.
// One outstanding imem request; stall buffering; redirect drop.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter int           S        = 32,
    parameter logic [S-1:0] RESET_PC = S'(DEF_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     reset,
    if_fetch_stage_if.master         imem,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [S-1:0]             redirect_pc,
    output logic [S-1:0]             if_inst,
    output logic [S-1:0]             if_pc,
    output logic                     if_valid
);

    localparam logic [S-1:0] NOP = S'(INST_NOP);

    fetch_state_e state, state_nxt;

    logic [S-1:0] pc;
    logic [S-1:0] pc_nxt;
    logic         pc_inc;
    logic [S-1:0] req_addr, req_nxt;
    logic [S-1:0] hold_inst, hold_inst_nxt;
    logic [S-1:0] hold_pc, hold_pc_nxt;
    logic [S-1:0] inst_nxt;
    logic [S-1:0] ipc_nxt;
    logic         val_nxt;

    // the pc advances whenever a non-redirected fetch completes
    assign pc_inc = (state == FETCH) && imem.imem_ready && !redirect;

    if_pc_reg #(
        .S        (S),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inc         (pc_inc),
        .base        (req_addr),
        .pc          (pc),
        .pc_nxt      (pc_nxt)
    );

    // request is driven straight from state so reset drops it at once
    assign imem.imem_req  = (state == FETCH) || (state == DROP);
    assign imem.imem_addr = req_addr;

    // next-state, request address, buffer and IF/ID output decode
    always_comb begin
        state_nxt     = state;
        req_nxt       = req_addr;
        hold_inst_nxt = hold_inst;
        hold_pc_nxt   = hold_pc;
        inst_nxt      = if_inst;
        ipc_nxt       = if_pc;
        val_nxt       = if_valid;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                req_nxt   = pc_nxt;
            end
            FETCH: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        req_nxt = pc_nxt;
                    end else begin
                        state_nxt = DROP;
                    end
                end else if (imem.imem_ready) begin
                    if (stall) begin
                        hold_inst_nxt = imem.imem_rdata;
                        hold_pc_nxt   = req_addr;
                        state_nxt     = HOLD;
                    end else begin
                        inst_nxt = imem.imem_rdata;
                        ipc_nxt  = req_addr;
                        val_nxt  = 1'b1;
                        req_nxt  = pc_nxt;
                    end
                end else if (!stall) begin
                    inst_nxt = NOP;
                    val_nxt  = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt = FETCH;
                    req_nxt   = pc_nxt;
                end else if (!stall) begin
                    inst_nxt  = hold_inst;
                    ipc_nxt   = hold_pc;
                    val_nxt   = 1'b1;
                    req_nxt   = pc_nxt;
                    state_nxt = FETCH;
                end
            end
            DROP: begin
                // old address stays on the bus until its response lands
                if (imem.imem_ready) begin
                    state_nxt = FETCH;
                    req_nxt   = pc_nxt;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (redirect) begin
            inst_nxt = NOP;
            val_nxt  = 1'b0;
        end
    end

    // state, request address and stall buffer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_addr  <= RESET_PC;
            hold_inst <= '0;
            hold_pc   <= '0;
        end else begin
            state     <= state_nxt;
            req_addr  <= req_nxt;
            hold_inst <= hold_inst_nxt;
            hold_pc   <= hold_pc_nxt;
        end
    end

    // IF/ID output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_inst  <= NOP;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            if_inst  <= inst_nxt;
            if_pc    <= ipc_nxt;
            if_valid <= val_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage.
// Memory returns addr+0x1000_0000 unless overridden.
module tb_if_fetch_stage;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        mem_auto;
    logic [31:0] mem_word;
    int          total;
    int          bad;

    if_fetch_stage_if #(.S(32)) imem ();

    if_fetch_stage #(.S(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory data: address-derived word or a forced value
    always_comb begin
        imem.imem_rdata = mem_word;
        if (mem_auto) begin
            imem.imem_rdata = imem.imem_addr + 32'h1000_0000;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc,
                           input logic [31:0] inst, input logic v);
        chk({tag, ".pc"}, if_pc, pc);
        chk({tag, ".inst"}, if_inst, inst);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_auto    = 1'b1;
        mem_word    = 32'h0;
        imem.imem_ready = 1'b1;

        #3;
        chk("rst.req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst.addr", imem.imem_addr, 32'h0);
        chk_out("rst", 32'h0, 32'h0, 1'b0);

        step();
        step();
        reset = 1'b1;

        step();
        chk("idle.req", {31'd0, imem.imem_req}, 32'd1);
        chk("f0.addr", imem.imem_addr, 32'h0);
        chk("f0.valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("f1.addr", imem.imem_addr, 32'h4);
        chk_out("f1", 32'h0, 32'h1000_0000, 1'b1);
        step();
        chk("f2.addr", imem.imem_addr, 32'h8);
        chk_out("f2", 32'h4, 32'h1000_0004, 1'b1);
        step();
        chk("f3.addr", imem.imem_addr, 32'hC);
        chk_out("f3", 32'h8, 32'h1000_0008, 1'b1);
        step();
        chk("f4.addr", imem.imem_addr, 32'h10);

        imem.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait.addr", imem.imem_addr, 32'h10);
            chk_out("wait", 32'hC, 32'h0, 1'b0);
        end
        imem.imem_ready = 1'b1;
        step();
        chk("wdone.addr", imem.imem_addr, 32'h14);
        chk_out("wdone", 32'h10, 32'h1000_0010, 1'b1);

        step();
        step();
        step();
        chk("pre_st.addr", imem.imem_addr, 32'h20);
        mem_auto = 1'b0;
        mem_word = 32'hDEAD_0000;
        stall    = 1'b1;
        step();
        chk("hold1.req", {31'd0, imem.imem_req}, 32'd0);
        chk_out("hold1", 32'h1C, 32'h1000_001C, 1'b1);
        mem_word = 32'hBAD0_BAD0;
        step();
        chk("hold2.req", {31'd0, imem.imem_req}, 32'd0);
        chk_out("hold2", 32'h1C, 32'h1000_001C, 1'b1);
        stall    = 1'b0;
        mem_auto = 1'b1;
        step();
        chk("unst.req", {31'd0, imem.imem_req}, 32'd1);
        chk("unst.addr", imem.imem_addr, 32'h24);
        chk_out("unst", 32'h20, 32'hDEAD_0000, 1'b1);

        for (int i = 0; i < 7; i++) begin
            step();
        end
        chk("pre_rd.addr", imem.imem_addr, 32'h40);
        chk("pre_rd.pc", if_pc, 32'h3C);
        imem.imem_ready = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        chk("drop1.addr", imem.imem_addr, 32'h40);
        chk("drop1.req", {31'd0, imem.imem_req}, 32'd1);
        chk_out("drop1", 32'h3C, 32'h0, 1'b0);
        step();
        chk("drop2.addr", imem.imem_addr, 32'h40);
        imem.imem_ready = 1'b1;
        step();
        chk("drop3.addr", imem.imem_addr, 32'h100);
        chk_out("drop3", 32'h3C, 32'h0, 1'b0);
        step();
        chk("tgt.addr", imem.imem_addr, 32'h104);
        chk_out("tgt", 32'h100, 32'h1000_0100, 1'b1);

        redirect    = 1'b1;
        redirect_pc = 32'h200;
        stall       = 1'b1;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("rds.req", {31'd0, imem.imem_req}, 32'd1);
        chk("rds.addr", imem.imem_addr, 32'h200);
        chk("rds.valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("rds2.addr", imem.imem_addr, 32'h204);
        chk_out("rds2", 32'h200, 32'h1000_0200, 1'b1);

        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        chk("top.addr", imem.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap.addr", imem.imem_addr, 32'h0);
        chk_out("wrap", 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b1);
        step();
        chk("wrap2.addr", imem.imem_addr, 32'h4);

        #2;
        reset = 1'b0;
        #1;
        chk("arst.req", {31'd0, imem.imem_req}, 32'd0);
        chk("arst.addr", imem.imem_addr, 32'h0);
        chk_out("arst", 32'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
